// File: rtl/divider_4_bit.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Define DIV_ZERO_CHECK_EN to short-cut a zero divisor straight to DONE.
module divider_4_bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             zero_skip;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

`ifdef DIV_ZERO_CHECK_EN
    assign zero_skip = (divisor == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // one restoring step: trial-subtract, keep shifted value on borrow
    always_comb begin
        trial   = {rem, dvd[WIDTH-1]} - {2'b00, dvs};
        rem_nxt = trial[WIDTH:0];
        quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH+1]};
        if (trial[WIDTH+1]) begin
            rem_nxt = {rem[WIDTH-1:0], dvd[WIDTH-1]};
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; a start in RUN is never accepted
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = zero_skip ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = zero_skip ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand latch, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd       <= '0;
            dvs       <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            dvd <= dividend;
            dvs <= divisor;
            quo <= '0;
            rem <= '0;
            cnt <= CW'(WIDTH);
            if (zero_skip) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            dvd <= dvd << 1;
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt - CW'(1);
            if (last) begin
                quotient  <= quo_nxt;
                remainder <= rem_nxt[WIDTH-1:0];
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic dbz_q;

    // zero-divisor flag, refreshed with every result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_q <= 1'b0;
        end else if (accept && zero_skip) begin
            dbz_q <= 1'b1;
        end else if (last) begin
            dbz_q <= 1'b0;
        end
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider_4_bit.sv
// Directed and exhaustive checks for divider_4_bit (WIDTH=4).
// Expected values come from hand tables and a / % reference.
module tb_divider_4_bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks;
    int failures;

    divider_4_bit #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl[8];

`ifdef DIV_ZERO_CHECK_EN
    localparam int ZLAT = 1;
    localparam logic ZFLAG = 1'b1;
`else
    localparam int ZLAT = 5;
    localparam logic ZFLAG = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // start one division and follow it to its done pulse
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] eq, input logic [3:0] er,
                           input logic ez, input int elat,
                           input string nm);
        int lat;
        bit seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (done) seen = 1;
        end
        chk({nm, " seen"}, 32'(seen), 32'd1);
        chk({nm, " lat"}, lat, elat);
        chk({nm, " q"}, 32'(quotient), 32'(eq));
        chk({nm, " r"}, 32'(remainder), 32'(er));
        chk({nm, " dz"}, 32'(div_by_zero), 32'(ez));
        @(posedge clk);
        #1;
        chk({nm, " pulse"}, 32'(done), 32'd0);
        chk({nm, " hold"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        int lat;
        int ndone;
        logic [3:0] gq;
        logic [3:0] gr;
        logic [3:0] eq;
        logic [3:0] er;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        tbl[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0,  5};
        tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0,  5};
        tbl[2] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0,  5};
        tbl[3] = '{4'd9,  4'd0,  4'd15, 4'd9, ZFLAG, ZLAT};
        tbl[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0,  5};
        tbl[5] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0,  5};
        tbl[6] = '{4'd14, 4'd3,  4'd4,  4'd2, 1'b0,  5};
        tbl[7] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0,  5};

        #3;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst q", 32'(quotient), 32'd0);
        chk("rst r", 32'(remainder), 32'd0);
        chk("rst dz", 32'(div_by_zero), 32'd0);

        // release just after an edge so the table's first start
        // lands on the first rising edge after deassertion
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                    tbl[i].z, tbl[i].lat, $sformatf("tbl%0d", i));
        end

        // start while RUN must be ignored
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        ndone = 0;
        lat   = 0;
        gq = '0;
        gr = '0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (lat == 0) lat = i;
                gq = quotient;
                gr = remainder;
            end
            if (i == 2) begin
                dividend = 4'd6;
                divisor  = 4'd2;
                start    = 1'b1;
            end
        end
        chk("ign ndone", ndone, 1);
        chk("ign lat", lat, 5);
        chk("ign q", 32'(gq), 32'd3);
        chk("ign r", 32'(gr), 32'd1);

        // start in the DONE cycle chains a second division
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("chain first", 32'(done), 32'd1);
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("chain busy", 32'(busy), 32'd1);
        lat = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("chain lat", lat, 5);
        chk("chain q", 32'(quotient), 32'd3);
        chk("chain r", 32'(remainder), 32'd0);

        // asynchronous reset mid-RUN
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst q", 32'(quotient), 32'd0);
        chk("arst r", 32'(remainder), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("arst no done", ndone, 0);

        // every operand pair against the reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                eq = (b == 0) ? 4'd15 : 4'(a / b);
                er = (b == 0) ? 4'(a) : 4'(a % b);
                run_div(4'(a), 4'(b), eq, er,
                        (b == 0) ? ZFLAG : 1'b0,
                        (b == 0) ? ZLAT : 5,
                        $sformatf("all %0d/%0d", a, b));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider_4_bit.md
DIVIDER_4_BIT -- requirements
Module: divider_4_bit

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled at rising clk edge.
REQ-005 dividend  input  WIDTH  unsigned dividend; sampled only on an accepted start.
REQ-006 divisor  input  WIDTH  unsigned divisor; sampled only on an accepted start.
REQ-007 busy  output  1  high while the division iterates (state RUN).
REQ-008 done  output  1  single-cycle pulse; quotient/remainder valid.
REQ-009 quotient  output  WIDTH  registered quotient.
REQ-010 remainder  output  WIDTH  registered remainder.
REQ-011 div_by_zero  output  1  registered flag; divisor was 0 for the current result.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE.
REQ-013 start SHALL be accepted when state is IDLE or DONE (busy=0); start in RUN SHALL be ignored, with no effect on operands or timing.
REQ-014 Accept at edge k SHALL latch operands, clear the partial remainder, load the iteration count with WIDTH, and enter RUN.
REQ-015 Each RUN edge SHALL perform one restoring step, MSB first: shift {partial remainder, next dividend bit} left; if the result >= divisor, subtract divisor and shift in quotient bit 1, else 0.
REQ-016 The partial remainder SHALL be WIDTH+1 bits internally; no overflow is permitted.
REQ-017 At edge k+WIDTH, quotient and remainder SHALL be registered, done SHALL go 1, and the state SHALL become DONE; latency from accept to done is WIDTH+1 cycles (5 for WIDTH=4).
REQ-018 At the edge leaving DONE, done SHALL return to 0; the next state SHALL be RUN if start is accepted at that edge, else IDLE.
REQ-019 quotient, remainder and div_by_zero SHALL hold their last values until the next done pulse.
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for divisor != 0.
REQ-021 When divisor = 0, the result SHALL be quotient = all ones and remainder = dividend (the natural restoring result).

Reset
REQ-022 rst_n low SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear internal registers.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-024 start SHALL be recognised from the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro DIV_ZERO_CHECK_EN defined: an accepted start with divisor = 0 SHALL skip RUN.
REQ-026 In that case the block SHALL enter DONE at the next edge with done=1, div_by_zero=1, quotient = all ones and remainder = dividend (latency 1).
REQ-027 Macro DIV_ZERO_CHECK_EN undefined: divisor = 0 SHALL take the normal WIDTH+1 latency with the REQ-021 result, and div_by_zero SHALL be tied 0.
REQ-028 div_by_zero SHALL be 0 for every nonzero-divisor result in both builds.

Verification
REQ-029 Dividend 13, divisor 4 -> done exactly 5 cycles after accept; quotient 3, remainder 1, div_by_zero 0.
REQ-030 Dividends 15/1 and 3/7 -> quotient 15 with remainder 0, and quotient 0 with remainder 3, respectively.
REQ-031 Dividend 9, divisor 0 -> with DIV_ZERO_CHECK_EN: done after 1 cycle, quotient 15, remainder 9, div_by_zero 1; without it: done after 5 cycles with the same quotient/remainder and div_by_zero 0.
REQ-032 Start 13/4, then start 6/2 two cycles later -> second start ignored; single done with 3/1.
REQ-033 Start asserted in the DONE cycle with 6/2 -> busy the next cycle, and a second done 5 cycles later with quotient 3, remainder 0.
REQ-034 rst_n pulsed low during RUN -> outputs 0 asynchronously, no done afterwards.
REQ-035 All 256 operand pairs checked against a/b and a%b (REQ-021 result for divisor 0).
